rough_opt: RTL and testbench



---
 rtl/rough_opt_pkg.sv | 35 +++
 rtl/rough_opt_regfile.sv | 23 ++
 rtl/rough_opt.sv | 254 +++++++++++++++++++++++++
 tb/tb_rough_opt.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rough_opt_pkg.sv
// Shared types and sizes for the rough_opt SPI master/slave peripheral.
package rough_opt_pkg;

  localparam int unsigned MEM_DEPTH = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);
  localparam int unsigned BIT_W     = $clog2(DATA_W);

  // Operating mode, encoded as {enable, strans}
  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_MASTER = 2'b01,
    MODE_MEM    = 2'b10,
    MODE_SLAVE  = 2'b11
  } mode_e;

  // Master serializer states
  typedef enum logic [1:0] {
    MST_IDLE  = 2'b00,
    MST_SHIFT = 2'b01,
    MST_DONE  = 2'b10
  } mst_state_e;

  // Register file write request
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  function automatic mode_e decode_mode(input logic en, input logic st);
    return mode_e'({en, st});
  endfunction

endpackage

// File: rtl/rough_opt_regfile.sv
// 8x8 register file: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module rough_opt_regfile
  import rough_opt_pkg::*;
(
  input  logic              clk,
  input  wr_req_t           wr_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_c_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_i.en) begin
      mem_q[wr_i.addr] <= wr_i.data;
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/rough_opt.sv
// SPI master/slave peripheral with a parallel-loaded 8x8 register file.
// MEM mode loads/reads the file, MASTER streams it out, SLAVE fills it.
module rough_opt
  import rough_opt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              strans,
  input  logic              read_write_,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] madd,
  output logic [DATA_W-1:0] out,
  input  logic              miso,
  output logic              mosi,
  output logic              mclk,
  output logic              cs,
  output logic              Miso,
  input  logic              Mosi,
  input  logic              Mclk,
  input  logic              Cs
);

  mode_e             mode_c;
  wr_req_t           wr_c;
  wr_req_t           slv_wr_c;
  logic [ADDR_W-1:0] raddr_c;
  logic [DATA_W-1:0] rdata_c;

  // Master state
  mst_state_e        mst_state_q, mst_state_d;
  logic [BIT_W-1:0]  mst_bit_q, mst_bit_d, mst_bit_nx;
  logic [ADDR_W-1:0] mst_addr_q, mst_addr_d, mst_addr_nx;
  logic              mst_phase_q, mst_phase_d;
  logic              cs_q, cs_d, mclk_q, mclk_d, mosi_q, mosi_d;

  // Slave state
  logic [1:0]        mclk_sync_q, mosi_sync_q, cs_sync_q;
  logic              mclk_prev_q;
  logic              mclk_s, mosi_s, cs_s, mclk_rise_c, mclk_fall_c;
  logic [BIT_W-1:0]  slv_bit_q, slv_bit_d;
  logic [DATA_W-1:0] slv_sh_q, slv_sh_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              smiso_q, smiso_d;

  // Parallel read data
  logic [DATA_W-1:0] out_q, out_d;

  // miso is reserved for a future full-duplex master
  logic unused_miso;
  assign unused_miso = miso;

  assign mode_c = decode_mode(enable, strans);

  rough_opt_regfile u_regfile (
    .clk       (clk),
    .wr_i      (wr_c),
    .raddr_i   (raddr_c),
    .rdata_c_o (rdata_c)
  );

  // Master look-ahead: the bit/address that goes out after the current one
  always_comb begin
    mst_bit_nx  = mst_bit_q - BIT_W'(1);
    mst_addr_nx = (mst_bit_q == '0) ? mst_addr_q + ADDR_W'(1) : mst_addr_q;
  end

  // Single read port shared by the modes, which never overlap
  always_comb begin
    raddr_c = '0;
    case (mode_c)
      MODE_MEM:    raddr_c = madd;
      MODE_MASTER: raddr_c = (mst_state_q == MST_SHIFT) ? mst_addr_nx : mst_addr_q;
      MODE_SLAVE:  raddr_c = waddr_q;
      default:     raddr_c = '0;
    endcase
  end

  // Write port: parallel write in MEM mode, otherwise the slave assembler
  always_comb begin
    wr_c = slv_wr_c;
    if (mode_c == MODE_MEM && !read_write_) begin
      wr_c.en   = 1'b1;
      wr_c.addr = madd;
      wr_c.data = data;
    end
  end

  // Parallel read register; holds when not reading
  always_comb begin
    out_d = out_q;
    if (mode_c == MODE_MEM && read_write_) begin
      out_d = rdata_c;
    end
  end

  // Master next-state: two clk cycles per bit, mclk low then high
  always_comb begin
    mst_state_d = mst_state_q;
    mst_bit_d   = mst_bit_q;
    mst_addr_d  = mst_addr_q;
    mst_phase_d = mst_phase_q;
    cs_d        = cs_q;
    mclk_d      = mclk_q;
    mosi_d      = mosi_q;
    if (mode_c != MODE_MASTER) begin
      mst_state_d = MST_IDLE;
      mst_bit_d   = '0;
      mst_addr_d  = '0;
      mst_phase_d = 1'b0;
      cs_d        = 1'b1;
      mclk_d      = 1'b0;
      mosi_d      = 1'b0;
    end else begin
      case (mst_state_q)
        MST_IDLE: begin
          mst_state_d = MST_SHIFT;
          mst_bit_d   = BIT_W'(DATA_W - 1);
          mst_addr_d  = '0;
          mst_phase_d = 1'b1;
          cs_d        = 1'b0;
          mclk_d      = 1'b0;
          mosi_d      = rdata_c[DATA_W-1];
        end
        MST_SHIFT: begin
          if (mst_phase_q) begin
            mclk_d      = 1'b1;
            mst_phase_d = 1'b0;
          end else if (mst_bit_q == '0 && mst_addr_q == ADDR_W'(MEM_DEPTH - 1)) begin
            mst_state_d = MST_DONE;
            mst_bit_d   = '0;
            mst_addr_d  = '0;
            cs_d        = 1'b1;
            mclk_d      = 1'b0;
            mosi_d      = 1'b0;
          end else begin
            mclk_d      = 1'b0;
            mst_phase_d = 1'b1;
            mst_bit_d   = mst_bit_nx;
            mst_addr_d  = mst_addr_nx;
            mosi_d      = rdata_c[mst_bit_nx];
          end
        end
        MST_DONE: begin
          mst_state_d = MST_DONE;
        end
        default: begin
          mst_state_d = MST_IDLE;
        end
      endcase
    end
  end

  // Master state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_state_q <= MST_IDLE;
      mst_bit_q   <= '0;
      mst_addr_q  <= '0;
      mst_phase_q <= 1'b0;
      cs_q        <= 1'b1;
      mclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      mst_state_q <= mst_state_d;
      mst_bit_q   <= mst_bit_d;
      mst_addr_q  <= mst_addr_d;
      mst_phase_q <= mst_phase_d;
      cs_q        <= cs_d;
      mclk_q      <= mclk_d;
      mosi_q      <= mosi_d;
    end
  end

  // Two-flop synchronizers for the slave link plus Mclk edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mclk_prev_q <= 1'b0;
    end else begin
      mclk_sync_q <= {mclk_sync_q[0], Mclk};
      mosi_sync_q <= {mosi_sync_q[0], Mosi};
      cs_sync_q   <= {cs_sync_q[0], Cs};
      mclk_prev_q <= mclk_sync_q[1];
    end
  end

  assign mclk_s      = mclk_sync_q[1];
  assign mosi_s      = mosi_sync_q[1];
  assign cs_s        = cs_sync_q[1];
  assign mclk_rise_c = mclk_s & ~mclk_prev_q;
  assign mclk_fall_c = ~mclk_s & mclk_prev_q;

  // Slave next-state: shift in on Mclk rise, drive Miso on Mclk fall.
  // While idle the MSB of the current byte is pre-driven so it is valid
  // before the first rising edge.
  always_comb begin
    slv_bit_d = slv_bit_q;
    slv_sh_d  = slv_sh_q;
    waddr_d   = waddr_q;
    smiso_d   = smiso_q;
    slv_wr_c  = '0;
    if (mode_c != MODE_SLAVE) begin
      slv_bit_d = '0;
      slv_sh_d  = '0;
      smiso_d   = 1'b0;
    end else if (cs_s) begin
      slv_bit_d = '0;
      slv_sh_d  = '0;
      smiso_d   = rdata_c[DATA_W-1];
    end else if (mclk_rise_c) begin
      slv_sh_d = {slv_sh_q[DATA_W-2:0], mosi_s};
      if (slv_bit_q == BIT_W'(DATA_W - 1)) begin
        slv_wr_c.en   = 1'b1;
        slv_wr_c.addr = waddr_q;
        slv_wr_c.data = slv_sh_d;
        waddr_d       = waddr_q + ADDR_W'(1);
        slv_bit_d     = '0;
      end else begin
        slv_bit_d = slv_bit_q + BIT_W'(1);
      end
    end else if (mclk_fall_c) begin
      smiso_d = rdata_c[BIT_W'(DATA_W - 1) - slv_bit_q];
    end else if (slv_bit_q == '0 && !mclk_s) begin
      smiso_d = rdata_c[DATA_W-1];
    end
  end

  // Slave and parallel-read state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slv_bit_q <= '0;
      slv_sh_q  <= '0;
      waddr_q   <= '0;
      smiso_q   <= 1'b0;
      out_q     <= '0;
    end else begin
      slv_bit_q <= slv_bit_d;
      slv_sh_q  <= slv_sh_d;
      waddr_q   <= waddr_d;
      smiso_q   <= smiso_d;
      out_q     <= out_d;
    end
  end

  assign out  = out_q;
  assign mosi = mosi_q;
  assign mclk = mclk_q;
  assign cs   = cs_q;
  assign Miso = smiso_q;

endmodule

// File: tb/tb_rough_opt.sv
// Scoreboard bench for rough_opt: stimulus queues expected bytes/bits,
// independent monitors pop and compare when the DUT presents them.
module tb_rough_opt;

  logic       clk = 1'b0;
  logic       rst, enable, strans, read_write_;
  logic [7:0] data;
  logic [2:0] madd;
  logic [7:0] out;
  logic       miso, mosi, mclk, cs, Miso, Mosi, Mclk, Cs;

  int checks = 0;
  int errors = 0;
  int mst_pulses = 0;

  logic [7:0] q_mem  [$];
  logic [7:0] q_mosi [$];
  logic       q_miso [$];

  logic [7:0] pat [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'h70};

  rough_opt dut (
    .clk(clk), .rst(rst), .enable(enable), .strans(strans),
    .read_write_(read_write_), .data(data), .madd(madd), .out(out),
    .miso(miso), .mosi(mosi), .mclk(mclk), .cs(cs),
    .Miso(Miso), .Mosi(Mosi), .Mclk(Mclk), .Cs(Cs)
  );

  always #2 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    {enable, strans} = m;
    read_write_ = 1'b1;
  endtask

  task automatic mem_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    enable = 1'b1; strans = 1'b0; read_write_ = 1'b0; madd = a; data = d;
  endtask

  task automatic mem_read(input logic [2:0] a, input logic [7:0] exp);
    @(negedge clk);
    enable = 1'b1; strans = 1'b0; read_write_ = 1'b1; madd = a;
    q_mem.push_back(exp);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; strans = 1'b0; read_write_ = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_frame();
    for (int i = 0; i < 8; i++) q_mosi.push_back(pat[i]);
  endtask

  // 40 ns Mclk period, data set up during the low phase
  task automatic spi_send(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      Mosi = b[i];
      #20 Mclk = 1'b1;
      #20 Mclk = 1'b0;
    end
  endtask

  // Monitor: parallel read data, one cycle after a MEM read is applied
  initial begin : mon_mem
    logic rd;
    logic [7:0] exp;
    forever begin
      @(posedge clk);
      rd = enable && !strans && read_write_ && !rst;
      #1;
      if (rd) begin
        if (q_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected: got %02h expected none", out);
        end else begin
          exp = q_mem.pop_front();
          check8("mem_out", out, exp);
        end
      end
    end
  end

  // Monitor: reassemble master bytes from mosi on mclk rising edges
  initial begin : mon_mst
    logic [7:0] sh;
    int nb;
    sh = '0; nb = 0;
    forever begin
      @(posedge mclk or posedge cs);
      if (cs === 1'b1) begin
        sh = '0; nb = 0;
      end else begin
        mst_pulses++;
        sh = {sh[6:0], mosi};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (q_mosi.size() == 0) begin
            checks++; errors++;
            $display("FAIL mosi_unexpected: got %02h expected none", sh);
          end else begin
            check8("mosi_byte", sh, q_mosi.pop_front());
          end
        end
      end
    end
  end

  // Monitor: chip select must be low at every master clock pulse
  initial begin : mon_cs
    forever begin
      @(posedge mclk);
      check8("cs_low_at_mclk", {7'd0, cs}, 8'h00);
    end
  end

  // Monitor: slave Miso seen on bench Mclk rising edges
  initial begin : mon_miso
    logic e;
    forever begin
      @(posedge Mclk);
      if (q_miso.size() != 0) begin
        e = q_miso.pop_front();
        check8("miso_bit", {7'd0, Miso}, {7'd0, e});
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; strans = 1'b0; read_write_ = 1'b1;
    data = '0; madd = '0; miso = 1'b0; Mosi = 1'b0; Mclk = 1'b0; Cs = 1'b1;
    repeat (3) @(negedge clk);
    check8("rst_out", out, 8'h00);
    check8("rst_cs", {7'd0, cs}, 8'h01);
    check8("rst_mosi", {7'd0, mosi}, 8'h00);
    check8("rst_mclk", {7'd0, mclk}, 8'h00);
    check8("rst_Miso", {7'd0, Miso}, 8'h00);
    rst = 1'b0;

    // MEM write then read-back
    for (int i = 0; i < 8; i++) mem_write(3'(i), pat[i]);
    for (int i = 0; i < 8; i++) mem_read(3'(i), pat[i]);
    set_mode(2'b00);

    // Full master frame
    pulse_rst();
    expect_frame();
    mst_pulses = 0;
    set_mode(2'b01);
    @(negedge clk);
    check8("mst_cs_fall", {7'd0, cs}, 8'h00);
    repeat (127) @(negedge clk);
    check8("mst_last_mclk", {7'd0, mclk}, 8'h01);
    check8("mst_last_cs", {7'd0, cs}, 8'h00);
    @(negedge clk);
    check8("mst_end_cs", {7'd0, cs}, 8'h01);
    check8("mst_end_mclk", {7'd0, mclk}, 8'h00);
    check8("mst_end_mosi", {7'd0, mosi}, 8'h00);
    repeat (11) @(negedge clk);
    check8("mst_done_cs", {7'd0, cs}, 8'h01);
    check_int("mst_pulses", mst_pulses, 64);
    check_int("mst_q_drained", q_mosi.size(), 0);
    set_mode(2'b00);

    // Reset after 20 bits
    expect_frame();
    mst_pulses = 0;
    set_mode(2'b01);
    repeat (41) @(negedge clk);
    check_int("mid_pulses", mst_pulses, 20);
    rst = 1'b1;
    #1;
    check8("mid_rst_cs", {7'd0, cs}, 8'h01);
    check8("mid_rst_mosi", {7'd0, mosi}, 8'h00);
    check8("mid_rst_mclk", {7'd0, mclk}, 8'h00);
    @(negedge clk);
    enable = 1'b0; strans = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q_mosi.delete();
    for (int i = 0; i < 8; i++) mem_read(3'(i), pat[i]);
    set_mode(2'b00);

    // Mode abort and restart from address 0, bit 7
    expect_frame();
    set_mode(2'b01);
    repeat (30) @(negedge clk);
    set_mode(2'b00);
    @(negedge clk);
    check8("abort_cs", {7'd0, cs}, 8'h01);
    check8("abort_mclk", {7'd0, mclk}, 8'h00);
    q_mosi.delete();
    expect_frame();
    mst_pulses = 0;
    set_mode(2'b01);
    repeat (140) @(negedge clk);
    check_int("reentry_pulses", mst_pulses, 64);
    check_int("reentry_q_drained", q_mosi.size(), 0);
    set_mode(2'b00);

    // Slave receive of three bytes
    pulse_rst();
    set_mode(2'b11);
    Cs = 1'b0;
    repeat (5) @(negedge clk);
    spi_send(8'hCC);
    spi_send(8'h72);
    spi_send(8'hFF);
    repeat (5) @(negedge clk);
    Cs = 1'b1;
    repeat (5) @(negedge clk);
    mem_read(3'd0, 8'hCC);
    mem_read(3'd1, 8'h72);
    mem_read(3'd2, 8'hFF);
    set_mode(2'b00);

    // Slave transmit of a preloaded byte
    pulse_rst();
    mem_write(3'd0, 8'hA5);
    set_mode(2'b11);
    Cs = 1'b0;
    repeat (5) @(negedge clk);
    q_miso.push_back(1'b1); q_miso.push_back(1'b0);
    q_miso.push_back(1'b1); q_miso.push_back(1'b0);
    q_miso.push_back(1'b0); q_miso.push_back(1'b1);
    q_miso.push_back(1'b0); q_miso.push_back(1'b1);
    spi_send(8'h3C);
    repeat (5) @(negedge clk);
    Cs = 1'b1;
    repeat (5) @(negedge clk);
    mem_read(3'd0, 8'h3C);
    set_mode(2'b00);
    repeat (4) @(negedge clk);

    check_int("mem_q_drained", q_mem.size(), 0);
    check_int("mosi_q_drained", q_mosi.size(), 0);
    check_int("miso_q_drained", q_miso.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
